// File: rtl/proc_pkg.sv
// Shared definitions for the boot loader: FSM states, frame constants and
// the running-checksum helper.
package proc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_CSUM = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } state_t;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
   localparam int         CSUM_W       = 8;

   // Running checksum: plain modulo-2^CSUM_W sum of payload bytes.
   function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] sum,
                                                  input logic [7:0]        data);
      csum_add = sum + data;
   endfunction

endpackage

// File: rtl/boot_loader.sv
// Boot loader: receives a framed program image (SYNC, LEN, payload, CSUM)
// over a valid/ready byte stream, writes the payload into program memory
// and releases the processor reset only when the checksum matches.
// The processor reset seen by the core is cpu_rst_o OR rst_i, so the core
// is held in reset during loader reset as well. Program memory is external
// and is never cleared here.
module boot_loader
   import proc_pkg::*;
#(
   parameter int         ADDR_W = 8,
   parameter logic [7:0] SYNC   = SYNC_DEFAULT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [7:0]        s_data_i,
   input  logic              s_valid_i,
   output logic              s_ready_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_wdata_o,
   output logic              cpu_rst_o,
   output logic              done_o,
   output logic              err_o
);

   // Byte counter must hold 2^ADDR_W and any 8-bit LEN value.
   localparam int CW = ((ADDR_W > 8) ? ADDR_W : 8) + 1;
   localparam logic [CW-1:0]     CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0]     CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]     CNT_FULL  = CNT_ONE << ADDR_W;
   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t              state_r;
   logic                ready_r;
   logic                we_r;
   logic [ADDR_W-1:0]   mem_addr_r;
   logic [7:0]          wdata_r;
   logic                cpu_rst_r;
   logic                done_r;
   logic                err_r;
   logic [CW-1:0]       count_r;
   logic [CSUM_W-1:0]   sum_r;
   logic [ADDR_W-1:0]   addr_r;
   logic                accept_s;

   assign accept_s = s_valid_i & ready_r;

   // Frame FSM with all outputs registered; state only moves on accepted bytes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r    <= ST_IDLE;
         ready_r    <= 1'b1;
         we_r       <= 1'b0;
         mem_addr_r <= ADDR_ZERO;
         wdata_r    <= 8'h00;
         cpu_rst_r  <= 1'b1;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         count_r    <= CNT_ZERO;
         sum_r      <= {CSUM_W{1'b0}};
         addr_r     <= ADDR_ZERO;
      end else begin
         // Write strobe is a single-cycle pulse following an accepted payload byte.
         we_r <= 1'b0;
         if (accept_s) begin
            case (state_r)
               ST_IDLE: begin
                  if (s_data_i == SYNC) begin
                     state_r <= ST_LEN;
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end
               ST_LEN: begin
                  if (s_data_i == 8'h00) begin
                     count_r <= CNT_FULL;
                  end else begin
                     count_r <= CW'(s_data_i);
                  end
                  addr_r  <= ADDR_ZERO;
                  sum_r   <= {CSUM_W{1'b0}};
                  state_r <= ST_DATA;
               end
               ST_DATA: begin
                  we_r       <= 1'b1;
                  mem_addr_r <= addr_r;
                  wdata_r    <= s_data_i;
                  sum_r      <= csum_add(sum_r, s_data_i);
                  addr_r     <= addr_r + ADDR_ONE;
                  count_r    <= count_r - CNT_ONE;
                  if (count_r == CNT_ONE) begin
                     state_r <= ST_CSUM;
                  end else begin
                     state_r <= ST_DATA;
                  end
               end
               ST_CSUM: begin
                  if (s_data_i == sum_r) begin
                     state_r   <= ST_DONE;
                     ready_r   <= 1'b0;
                     cpu_rst_r <= 1'b0;
                     done_r    <= 1'b1;
                  end else begin
                     state_r   <= ST_ERR;
                     err_r     <= 1'b1;
                  end
               end
               ST_ERR: begin
                  if (s_data_i == SYNC) begin
                     err_r   <= 1'b0;
                     state_r <= ST_LEN;
                  end else begin
                     state_r <= ST_ERR;
                  end
               end
               ST_DONE: begin
                  state_r <= ST_DONE;
               end
               default: begin
                  state_r   <= ST_IDLE;
                  ready_r   <= 1'b1;
                  cpu_rst_r <= 1'b1;
                  done_r    <= 1'b0;
                  err_r     <= 1'b0;
               end
            endcase
         end
      end
   end

   assign s_ready_o   = ready_r;
   assign mem_we_o    = we_r;
   assign mem_addr_o  = mem_addr_r;
   assign mem_wdata_o = wdata_r;
   assign cpu_rst_o   = cpu_rst_r;
   assign done_o      = done_r;
   assign err_o       = err_r;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: an 8-bit-address instance for most frames
// and a 4-bit-address instance for the full-size wrapping image.
module tb_boot_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] s_data = 8'h00;
   logic       s_valid = 1'b0;
   logic       sel4 = 1'b0;

   logic       valid0, valid4;
   logic       rdy0, we0, crst0, done0, err0;
   logic [7:0] addr0, wd0;
   logic       rdy4, we4, crst4, done4, err4;
   logic [3:0] addr4;
   logic [7:0] wd4;

   int checks = 0;
   int errors = 0;

   logic [15:0] q0[$];
   logic [11:0] q4[$];

   assign valid0 = s_valid & ~sel4;
   assign valid4 = s_valid & sel4;

   always #5 clk = ~clk;

   boot_loader #(.ADDR_W(8), .SYNC(8'hA5)) dut0 (
      .clk_i(clk), .rst_i(rst), .s_data_i(s_data), .s_valid_i(valid0),
      .s_ready_o(rdy0), .mem_we_o(we0), .mem_addr_o(addr0), .mem_wdata_o(wd0),
      .cpu_rst_o(crst0), .done_o(done0), .err_o(err0));

   boot_loader #(.ADDR_W(4), .SYNC(8'hA5)) dut4 (
      .clk_i(clk), .rst_i(rst), .s_data_i(s_data), .s_valid_i(valid4),
      .s_ready_o(rdy4), .mem_we_o(we4), .mem_addr_o(addr4), .mem_wdata_o(wd4),
      .cpu_rst_o(crst4), .done_o(done4), .err_o(err4));

   // Record every write strobe, sampled mid-cycle.
   always @(negedge clk) begin
      if (we0) q0.push_back({addr0, wd0});
      if (we4) q4.push_back({addr4, wd4});
   end

   task automatic do_reset();
      s_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      q0.delete();
      q4.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      logic got;
      int   n;
      repeat (gap) begin
         s_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      s_data  = b;
      s_valid = 1'b1;
      got = 1'b0;
      n = 0;
      while (!got && n < 50) begin
         got = sel4 ? rdy4 : rdy0;
         @(posedge clk);
         #1;
         n++;
      end
      s_valid = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL send_timeout byte=%h not accepted within 50 cycles", b);
      end
   endtask

   task automatic send_frame(input logic [7:0] f[$], input int maxgap);
      foreach (f[i]) send_byte(f[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({rdy0, we0, addr0, wd0, crst0, done0, err0} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_values got rdy=%b we=%b addr=%h wd=%h crst=%b done=%b err=%b required 1 0 00 00 1 0 0",
                  rdy0, we0, addr0, wd0, crst0, done0, err0);
      end
      checks++;
      if ({rdy4, we4, addr4, crst4, done4, err4} !== {1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_values4 got rdy=%b we=%b addr=%h crst=%b done=%b err=%b", rdy4, we4, addr4, crst4, done4, err4);
      end
   endtask

   task automatic check_basic_writes(input string name);
      logic [15:0] exp[$];
      exp = '{16'h0011, 16'h0122, 16'h0233};
      checks++;
      if (q0.size() != exp.size()) begin
         errors++;
         $display("FAIL %s_write_count got %0d required %0d", name, q0.size(), exp.size());
      end else begin
         foreach (exp[i]) begin
            checks++;
            if (q0[i] !== exp[i]) begin
               errors++;
               $display("FAIL %s_write%0d got %h required %h", name, i, q0[i], exp[i]);
            end
         end
      end
   endtask

   task automatic test_basic();
      logic [7:0] f[$];
      int         nw;
      do_reset();
      f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
      send_frame(f, 0);
      checks++;
      if (done0 !== 1'b0 || crst0 !== 1'b1) begin
         errors++;
         $display("FAIL basic_before_csum got done=%b crst=%b required 0 1", done0, crst0);
      end
      send_byte(8'h66, 0);
      checks++;
      if ({done0, crst0, err0, rdy0} !== 4'b1000) begin
         errors++;
         $display("FAIL basic_done got done=%b crst=%b err=%b rdy=%b required 1 0 0 0", done0, crst0, err0, rdy0);
      end
      check_basic_writes("basic");
      // DONE ignores further traffic.
      nw = q0.size();
      s_data = 8'hA5;
      s_valid = 1'b1;
      repeat (4) @(posedge clk);
      #1 s_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({done0, crst0, rdy0} !== 3'b100 || q0.size() != nw) begin
         errors++;
         $display("FAIL done_hold got done=%b crst=%b rdy=%b writes=%0d required 1 0 0 %0d", done0, crst0, rdy0, q0.size(), nw);
      end
   endtask

   task automatic test_err_recover();
      logic [7:0] f[$];
      do_reset();
      f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h67};
      send_frame(f, 0);
      checks++;
      if ({err0, crst0, done0, rdy0} !== 4'b1101) begin
         errors++;
         $display("FAIL csum_bad got err=%b crst=%b done=%b rdy=%b required 1 1 0 1", err0, crst0, done0, rdy0);
      end
      send_byte(8'h42, 0);
      checks++;
      if (err0 !== 1'b1) begin
         errors++;
         $display("FAIL err_discard got err=%b required 1", err0);
      end
      send_byte(8'hA5, 0);
      checks++;
      if (err0 !== 1'b0 || crst0 !== 1'b1) begin
         errors++;
         $display("FAIL err_sync_clear got err=%b crst=%b required 0 1", err0, crst0);
      end
      q0.delete();
      f = '{8'h01, 8'hFF, 8'hFF};
      send_frame(f, 0);
      checks++;
      if ({done0, crst0, err0} !== 3'b100 || q0.size() != 1) begin
         errors++;
         $display("FAIL err_reload got done=%b crst=%b err=%b writes=%0d required 1 0 0 1", done0, crst0, err0, q0.size());
      end else begin
         checks++;
         if (q0[0] !== 16'h00FF) begin
            errors++;
            $display("FAIL err_reload_write got %h required 00ff", q0[0]);
         end
      end
   endtask

   task automatic test_sync_hunt();
      logic [7:0] f[$];
      do_reset();
      f = '{8'h00, 8'h12, 8'hA5, 8'h01, 8'hA5, 8'hA5};
      send_frame(f, 0);
      checks++;
      if (done0 !== 1'b1 || q0.size() != 1) begin
         errors++;
         $display("FAIL sync_hunt got done=%b writes=%0d required 1 1", done0, q0.size());
      end else begin
         checks++;
         if (q0[0] !== 16'h00A5) begin
            errors++;
            $display("FAIL sync_hunt_write got %h required 00a5", q0[0]);
         end
      end
   endtask

   task automatic test_full_wrap();
      logic [7:0] f[$];
      do_reset();
      sel4 = 1'b1;
      f = '{8'hA5, 8'h00};
      for (int i = 1; i <= 16; i++) f.push_back(8'(i));
      send_frame(f, 0);
      checks++;
      if (done4 !== 1'b0) begin
         errors++;
         $display("FAIL wrap_early_done got done=%b required 0", done4);
      end
      send_byte(8'h88, 0);
      sel4 = 1'b0;
      checks++;
      if ({done4, crst4, err4} !== 3'b100) begin
         errors++;
         $display("FAIL wrap_done got done=%b crst=%b err=%b required 1 0 0", done4, crst4, err4);
      end
      checks++;
      if (q4.size() != 16) begin
         errors++;
         $display("FAIL wrap_count got %0d required 16", q4.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            checks++;
            if (q4[i] !== {4'(i), 8'(i + 1)}) begin
               errors++;
               $display("FAIL wrap_write%0d got %h required %h", i, q4[i], {4'(i), 8'(i + 1)});
            end
         end
      end
   endtask

   task automatic test_gaps();
      logic [7:0] f[$];
      do_reset();
      f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
      send_frame(f, 3);
      checks++;
      if (done0 !== 1'b1 || crst0 !== 1'b0) begin
         errors++;
         $display("FAIL gaps_done got done=%b crst=%b required 1 0", done0, crst0);
      end
      check_basic_writes("gaps");
   endtask

   task automatic test_mid_reset();
      logic [7:0] f[$];
      do_reset();
      f = '{8'hA5, 8'h03, 8'h11, 8'h22};
      send_frame(f, 0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({crst0, done0, err0, rdy0, we0} !== 5'b10010 || q0.size() != 2) begin
         errors++;
         $display("FAIL mid_reset got crst=%b done=%b err=%b rdy=%b we=%b writes=%0d required 1 0 0 1 0 2",
                  crst0, done0, err0, rdy0, we0, q0.size());
      end
      q0.delete();
      f = '{8'hA5, 8'h02, 8'h05, 8'h06, 8'h0B};
      send_frame(f, 0);
      checks++;
      if (done0 !== 1'b1 || q0.size() != 2) begin
         errors++;
         $display("FAIL mid_reset_reload got done=%b writes=%0d required 1 2", done0, q0.size());
      end else begin
         checks++;
         if (q0[0] !== 16'h0005 || q0[1] !== 16'h0106) begin
            errors++;
            $display("FAIL mid_reset_writes got %h %h required 0005 0106", q0[0], q0[1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_err_recover();
      test_sync_hunt();
      test_full_wrap();
      test_gaps();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global bound so a stuck run still terminates.
   initial begin
      #1000000;
      $display("FAIL global_timeout simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
